// File: rtl/wb_fabric_pkg.sv
// Shared definitions for the Wishbone fabric decoder: FSM encoding, RAM region
// codes, the default read value and small helpers.
package wb_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SLV_WAIT = 2'd1,
    SELF_ACK = 2'd2,
    DONE     = 2'd3
  } state_e;

  typedef enum logic {
    SEL_RAM0 = 1'b0,
    SEL_RAM1 = 1'b1
  } ram_sel_e;

  localparam int unsigned REGION_LSB = 11;
  localparam logic [5:0]  RAM0_REGION_C   = 6'h00;
  localparam logic [5:0]  RAM1_REGION_C   = 6'h01;
  localparam logic [31:0] DEF_REG_VALUE_C = 32'hFABDEFAC;

  // The first SLV_WAIT cycle already counts as one wait cycle.
  localparam logic [7:0] TMO_LOAD_C = 8'd1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Loadable 8-bit up-counter; tc is high while the count equals tc_val, and the
// count holds there until the next load.
module wb_timeout_cnt
  import wb_fabric_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic [7:0] tc_val,
  output logic       tc
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tc = (cnt_q == tc_val);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_fabric_decoder.sv
// Wishbone address decoder and response stage for the fabric RAM block.
// Optional build macro WB_DECODER_ERR_EN adds WBs_ERR_o for self-terminated cycles.
module wb_fabric_decoder
  import wb_fabric_pkg::*;
#(
  parameter int                        ADDRWIDTH      = 17,
  parameter int                        DATAWIDTH      = 32,
  parameter logic [ADDRWIDTH-12:0]     RAM0_REGION    = RAM0_REGION_C,
  parameter logic [ADDRWIDTH-12:0]     RAM1_REGION    = RAM1_REGION_C,
  parameter int                        TIMEOUT_CYCLES = 16,
  parameter logic [DATAWIDTH-1:0]      DEF_REG_VALUE  = DEF_REG_VALUE_C
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  output logic                 WBs_ACK_o,
  output logic                 WBs_RAM0_CYC_o,
  output logic                 WBs_RAM1_CYC_o,
  input  logic [DATAWIDTH-1:0] WBs_RAM0_DAT_i,
  input  logic [DATAWIDTH-1:0] WBs_RAM1_DAT_i,
  input  logic                 WBs_SLV_ACK_i,
`ifdef WB_DECODER_ERR_EN
  output logic                 WBs_ERR_o,
`endif
  output logic                 Timeout_Sts_o,
  output logic [7:0]           Err_Cnt_o
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  ram_sel_e   sel_q, sel_d;
  logic       self_ack_q, self_ack_d;
  logic       tmo_q, tmo_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic                  req;
  logic [ADDRWIDTH-12:0] region;
  logic                  hit0, hit1;
  logic                  slv_done;
  logic                  tmo_tc;
  logic                  cnt_load;
  logic                  cnt_en;

  // Write enable and in-region offset are consumed by the RAMs, not here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, WBs_WE_i, WBs_ADR_i[REGION_LSB-1:0]};

  assign req      = WBs_CYC_i & WBs_STB_i;
  assign region   = WBs_ADR_i[ADDRWIDTH-1:REGION_LSB];
  assign hit0     = (region == RAM0_REGION);
  assign hit1     = (region == RAM1_REGION);
  assign slv_done = (state_q == SLV_WAIT) & WBs_CYC_i & WBs_SLV_ACK_i;
  assign cnt_load = (state_q == IDLE) & req & (hit0 | hit1);
  assign cnt_en   = (state_q == SLV_WAIT);

  wb_timeout_cnt u_tmo_cnt (
    .clk      (WBs_CLK_i),
    .rst      (WBs_RST_i),
    .load     (cnt_load),
    .load_val (TMO_LOAD_C),
    .en       (cnt_en),
    .tc_val   (TC_VAL),
    .tc       (tmo_tc)
  );

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q    <= IDLE;
      sel_q      <= SEL_RAM0;
      self_ack_q <= 1'b0;
      tmo_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      self_ack_q <= self_ack_d;
      tmo_q      <= tmo_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tmo_d      = tmo_q;
    err_cnt_d  = err_cnt_q;
    self_ack_d = (state_q == SELF_ACK);
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit0 | hit1) begin
            state_d = SLV_WAIT;
            sel_d   = hit0 ? SEL_RAM0 : SEL_RAM1;
          end else begin
            state_d = SELF_ACK;
          end
        end
      end
      SLV_WAIT: begin
        // Abandoned cycle beats slave ACK, which beats the timeout.
        if (!WBs_CYC_i || WBs_SLV_ACK_i) begin
          state_d = DONE;
        end else if (tmo_tc) begin
          state_d = SELF_ACK;
          tmo_d   = 1'b1;
        end
      end
      SELF_ACK: begin
        state_d   = DONE;
        err_cnt_d = sat_inc8(err_cnt_q);
      end
      DONE: begin
        if (!WBs_STB_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The self-terminated response is registered out of SELF_ACK so that
  // unmapped accesses see the same two-cycle latency as a prompt slave.
  always_comb begin
    WBs_RAM0_CYC_o = (state_q == SLV_WAIT) && (sel_q == SEL_RAM0);
    WBs_RAM1_CYC_o = (state_q == SLV_WAIT) && (sel_q == SEL_RAM1);
    WBs_DAT_o      = '0;
    if (slv_done) begin
      WBs_DAT_o = (sel_q == SEL_RAM1) ? WBs_RAM1_DAT_i : WBs_RAM0_DAT_i;
    end else if (self_ack_q) begin
      WBs_DAT_o = DEF_REG_VALUE;
    end
`ifdef WB_DECODER_ERR_EN
    WBs_ACK_o = slv_done;
    WBs_ERR_o = self_ack_q;
`else
    WBs_ACK_o = slv_done | self_ack_q;
`endif
  end

  assign Timeout_Sts_o = tmo_q;
  assign Err_Cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_wb_fabric_decoder.sv
// Scoreboard bench for wb_fabric_decoder: each access pushes its expected
// response; a negedge monitor pops and compares whenever the DUT responds.
module tb_wb_fabric_decoder;

  localparam int          AW  = 17;
  localparam int          DW  = 32;
  localparam int          TMO = 16;
  localparam logic [31:0] DEF = 32'hFABDEFAC;
`ifdef WB_DECODER_ERR_EN
  localparam logic [1:0]  SELF_KIND = 2'b01;
`else
  localparam logic [1:0]  SELF_KIND = 2'b10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] adr = '0;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we  = 1'b0;
  logic [DW-1:0] ram0_dat = 32'h1234_0000;
  logic [DW-1:0] ram1_dat = 32'h0000_00A5;
  logic          slv_ack  = 1'b0;
  logic [DW-1:0] dat_o;
  logic          ack_o;
  logic          ram0_cyc;
  logic          ram1_cyc;
  logic          tmo_sts;
  logic [7:0]    err_cnt;
  logic          err_o;

  wb_fabric_decoder #(
    .ADDRWIDTH      (AW),
    .DATAWIDTH      (DW),
    .RAM0_REGION    (6'h00),
    .RAM1_REGION    (6'h01),
    .TIMEOUT_CYCLES (TMO),
    .DEF_REG_VALUE  (DEF)
  ) dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_i      (rst),
    .WBs_ADR_i      (adr),
    .WBs_CYC_i      (cyc),
    .WBs_STB_i      (stb),
    .WBs_WE_i       (we),
    .WBs_DAT_o      (dat_o),
    .WBs_ACK_o      (ack_o),
    .WBs_RAM0_CYC_o (ram0_cyc),
    .WBs_RAM1_CYC_o (ram1_cyc),
    .WBs_RAM0_DAT_i (ram0_dat),
    .WBs_RAM1_DAT_i (ram1_dat),
    .WBs_SLV_ACK_i  (slv_ack),
`ifdef WB_DECODER_ERR_EN
    .WBs_ERR_o      (err_o),
`endif
    .Timeout_Sts_o  (tmo_sts),
    .Err_Cnt_o      (err_cnt)
  );

`ifndef WB_DECODER_ERR_EN
  assign err_o = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc_no = 0;
  always @(posedge clk) cyc_no++;

  typedef struct {
    logic [31:0] data;
    int          at;
    logic [1:0]  kind;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         resp_cnt = 0;
  logic       prev_resp = 1'b0;
  logic [7:0] exp_err_cnt = 8'd0;
  logic       exp_tmo = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_resp = 1'b0;
    end else begin
      if (ack_o || err_o) begin
        check("resp_b2b", {31'd0, prev_resp}, 32'd0);
        resp_cnt++;
        if (sb.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_data", dat_o, e.data);
          check("resp_cycle", cyc_no, e.at);
          check("resp_kind", {30'd0, ack_o, err_o}, {30'd0, e.kind});
        end
      end else begin
        check("dat_idle", dat_o, 32'd0);
      end
      prev_resp = ack_o || err_o;
    end
  end

  // ack_at: slave ACKs on the n-th cycle CYC_o is up (0 = never).
  task automatic access(input logic [5:0] region, input logic [10:0] offs, input logic wr,
                        input int ack_at, input logic late_ack, input logic [31:0] exp_data,
                        input int exp_lat, input logic self_term, input int exp_w0,
                        input int exp_w1);
    int   t0, r0, n, w0, w1;
    logic got, mapped;
    mapped = (region == 6'h00) || (region == 6'h01);
    @(posedge clk); #1;
    adr = {region, offs}; we = wr; cyc = 1'b1; stb = 1'b1;
    t0 = cyc_no; r0 = resp_cnt; n = 0; w0 = 0; w1 = 0; got = 1'b0;
    sb.push_back('{exp_data, t0 + exp_lat, self_term ? SELF_KIND : 2'b10});
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (resp_cnt != r0) begin
        got = 1'b1;
      end else begin
        if (ram0_cyc || ram1_cyc) n++;
        slv_ack = (ram0_cyc || ram1_cyc) && (n == ack_at);
        w0 += int'(ram0_cyc && !slv_ack);
        w1 += int'(ram1_cyc && !slv_ack);
      end
    end
    if (!got) begin
      check("resp_missing", 32'd0, 32'd1);
      sb.delete();
    end
    if (late_ack) begin
      slv_ack = 1'b1;
      @(posedge clk); #1;
    end
    slv_ack = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (self_term) exp_err_cnt = (exp_err_cnt == 8'hFF) ? exp_err_cnt : exp_err_cnt + 8'd1;
    if (self_term && mapped) exp_tmo = 1'b1;
    check("err_cnt", {24'd0, err_cnt}, {24'd0, exp_err_cnt});
    check("tmo_sts", {31'd0, tmo_sts}, {31'd0, exp_tmo});
    check("ram0_wait_cycles", w0, exp_w0);
    check("ram1_wait_cycles", w1, exp_w1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},  {31'd0, ack_o}, 32'd0);
    check({tag, "_err"},  {31'd0, err_o}, 32'd0);
    check({tag, "_dat"},  dat_o, 32'd0);
    check({tag, "_cyc0"}, {31'd0, ram0_cyc}, 32'd0);
    check({tag, "_cyc1"}, {31'd0, ram1_cyc}, 32'd0);
    check({tag, "_tmo"},  {31'd0, tmo_sts}, 32'd0);
    check({tag, "_ecnt"}, {24'd0, err_cnt}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    // RAM0 write, prompt slave
    access(6'h00, 11'h005, 1'b1, 2, 1'b0, 32'h1234_0000, 2, 1'b0, 1, 0);
    // RAM1 read at top of region
    access(6'h01, 11'h7FF, 1'b0, 2, 1'b0, 32'h0000_00A5, 2, 1'b0, 0, 1);
    // unmapped read and unmapped write
    access(6'h3F, 11'h000, 1'b0, 2, 1'b0, DEF, 2, 1'b1, 0, 0);
    access(6'h02, 11'h010, 1'b1, 0, 1'b0, DEF, 2, 1'b1, 0, 0);
    // hung slave: self-ack 16 cycles after CYC_o, late ACK must be ignored
    access(6'h00, 11'h020, 1'b0, 0, 1'b1, DEF, TMO + 1, 1'b1, TMO - 1, 0);
    // ACK on the terminal-count cycle wins over the timeout
    ram1_dat = 32'h5A5A_C3C3;
    access(6'h01, 11'h100, 1'b0, TMO - 1, 1'b0, 32'h5A5A_C3C3, TMO - 1, 1'b0, 0, TMO - 2);

    // CYC dropped mid-wait: no response, no error
    @(posedge clk); #1;
    adr = {6'h00, 11'h033}; cyc = 1'b1; stb = 1'b1;
    repeat (2) @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_cyc0", {31'd0, ram0_cyc}, 32'd0);
    check("abort_err_cnt", {24'd0, err_cnt}, {24'd0, exp_err_cnt});
    access(6'h00, 11'h034, 1'b0, 1, 1'b0, 32'h1234_0000, 1, 1'b0, 0, 0);

    // reset in the middle of SLV_WAIT
    @(posedge clk); #1;
    adr = {6'h01, 11'h044}; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("pre_rst_cyc1", {31'd0, ram1_cyc}, 32'd1);
    rst = 1'b1;
    #1 check_all_zero("mid_rst");
    cyc = 1'b0; stb = 1'b0;
    exp_err_cnt = 8'd0; exp_tmo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      access(6'h20 + 6'(i % 16), 11'(i), 1'(i % 2), 0, 1'b0, DEF, 2, 1'b1, 0, 0);
    end
    check("err_cnt_sat", {24'd0, err_cnt}, 32'h0000_00FF);

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
